// File: rtl/pattern_load_arbiter.sv
// Arbitrates the single-port frame RAM between the SD pattern loader and the life engine.
// Sequences file loads (engine drain, reader restart, bit-count check) with a 1-deep pending slot.
module pattern_load_arbiter #(
   parameter int                ADDR_W     = 24,
   parameter int                FILE_W     = 16,
   parameter logic [FILE_W-1:0] BOOT_FILE  = 16'd0,
   parameter int                FRAME_BITS = 524288,
   parameter int                TIMEOUT    = 2**26
) (
   input  logic              clk_spi,
   input  logic              reset,
   input  logic              load_req,
   input  logic [FILE_W-1:0] load_file_id,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_error,
   output logic [FILE_W-1:0] rd_file_id,
   input  logic              rd_finish,
   input  logic [ADDR_W-1:0] ld_address,
   input  logic              ld_wren,
   input  logic              ld_write_data,
   output logic              eng_pause,
   input  logic              eng_idle,
   input  logic              eng_req,
   output logic              eng_gnt,
   input  logic [ADDR_W-1:0] eng_address,
   input  logic              eng_wren,
   input  logic              eng_rden,
   input  logic              eng_write_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_wren,
   output logic              mem_rden,
   output logic              mem_write_data
);

   localparam int                CNT_W     = 20;
   localparam int                TMO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRAIN = 3'd1,
      S_ISSUE = 3'd2,
      S_LOAD  = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   state_t            r_state,      w_next_state;
   logic [FILE_W-1:0] r_rd_file_id, w_rd_file_id;
   logic [FILE_W-1:0] r_cur_id,     w_cur_id;
   logic [FILE_W-1:0] r_req_id,     w_req_id;
   logic [FILE_W-1:0] r_pend_id,    w_pend_id;
   logic              r_pending,    w_pending;
   logic [CNT_W-1:0]  r_ld_cnt,     w_ld_cnt;
   logic [TMO_W-1:0]  r_tmo,        w_tmo;

   // State and datapath registers; reset lands directly in the boot load.
   always_ff @(posedge clk_spi) begin
      if (reset) begin
         r_state      <= S_LOAD;
         r_rd_file_id <= BOOT_FILE;
         r_cur_id     <= BOOT_FILE;
         r_req_id     <= BOOT_FILE;
         r_pend_id    <= BOOT_FILE;
         r_pending    <= 1'b0;
         r_ld_cnt     <= {CNT_W{1'b0}};
         r_tmo        <= {TMO_W{1'b0}};
      end else begin
         r_state      <= w_next_state;
         r_rd_file_id <= w_rd_file_id;
         r_cur_id     <= w_cur_id;
         r_req_id     <= w_req_id;
         r_pend_id    <= w_pend_id;
         r_pending    <= w_pending;
         r_ld_cnt     <= w_ld_cnt;
         r_tmo        <= w_tmo;
      end
   end

   // Next-state, memory ownership mux and grant.
   always_comb begin
      w_next_state   = r_state;
      w_rd_file_id   = r_rd_file_id;
      w_cur_id       = r_cur_id;
      w_req_id       = r_req_id;
      w_pend_id      = r_pend_id;
      w_pending      = r_pending;
      w_ld_cnt       = r_ld_cnt;
      w_tmo          = r_tmo;
      eng_gnt        = 1'b0;
      mem_address    = {ADDR_W{1'b0}};
      mem_wren       = 1'b0;
      mem_rden       = 1'b0;
      mem_write_data = 1'b0;

      // Requests arriving while busy park in the pending slot, last one wins.
      if (load_req && (r_state != S_IDLE)) begin
         w_pending = 1'b1;
         w_pend_id = load_file_id;
      end else begin
         w_pending = r_pending;
      end

      case (r_state)
         S_IDLE: begin
            eng_gnt = eng_req;
            if (eng_req) begin
               mem_address    = eng_address;
               mem_wren       = eng_wren;
               mem_rden       = eng_rden;
               mem_write_data = eng_write_data;
            end else begin
               mem_wren = 1'b0;
            end
            if (load_req) begin
               if (load_file_id == r_cur_id) begin
                  w_next_state = S_DONE;
               end else begin
                  w_req_id     = load_file_id;
                  w_next_state = S_DRAIN;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (eng_idle) begin
               w_rd_file_id = r_req_id;
               w_cur_id     = r_req_id;
               w_ld_cnt     = {CNT_W{1'b0}};
               w_tmo        = {TMO_W{1'b0}};
               w_next_state = S_ISSUE;
            end else begin
               w_next_state = S_DRAIN;
            end
         end
         S_ISSUE: begin
            w_tmo = r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
            if (r_tmo == TMO_LAST) begin
               w_next_state = S_ERROR;
            end else if (!rd_finish) begin
               w_next_state = S_LOAD;
            end else begin
               w_next_state = S_ISSUE;
            end
         end
         S_LOAD: begin
            mem_address    = ld_address;
            mem_wren       = ld_wren;
            mem_write_data = ld_write_data;
            w_tmo          = r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
            if (ld_wren && (r_ld_cnt != {CNT_W{1'b1}})) begin
               w_ld_cnt = r_ld_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               w_ld_cnt = r_ld_cnt;
            end
            // A finishing reader is judged on its count before the timeout is considered.
            if (rd_finish) begin
               w_next_state = (r_ld_cnt == FRAME_CNT) ? S_DONE : S_ERROR;
            end else if (r_tmo == TMO_LAST) begin
               w_next_state = S_ERROR;
            end else begin
               w_next_state = S_LOAD;
            end
         end
         S_DONE, S_ERROR: begin
            if (r_pending || load_req) begin
               w_req_id     = load_req ? load_file_id : r_pend_id;
               w_pending    = 1'b0;
               w_next_state = S_DRAIN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign load_busy  = (r_state != S_IDLE) || r_pending;
   assign eng_pause  = (r_state != S_IDLE);
   assign load_done  = (r_state == S_DONE);
   assign load_error = (r_state == S_ERROR);
   assign rd_file_id = r_rd_file_id;

endmodule
